// File: rtl/divmod_seq_ctrl.sv
// Restoring divide sequencer: one quotient bit per clock, fixed-point quotient plus remainder.
// Optional DIVMOD_EARLY_EXIT_EN ends iteration once the partial remainder and remaining dividend bits are zero.
//
//   state | meaning
//   IDLE  | waiting for an operand pair (in_ready high)
//   ITER  | shifting/subtracting, one quotient bit per clock (busy high)
//   DONE  | result presented, held until out_ready (out_valid high)
module divmod_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int FRAC  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      op1,
  input  logic [WIDTH-1:0]      op2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH+FRAC-1:0] quotient,
  output logic [WIDTH-1:0]      remainder,
  output logic                  div_zero,
  output logic                  busy
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t         state;
  logic [N-1:0]   dvd;
  logic [N-1:0]   q_sr;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] diff;
  logic             p_ge;
  logic [WIDTH-1:0] p_nx;
  logic [N-1:0]     q_nx;
  logic [N-1:0]     dvd_nx;
  logic             last_step;
  logic             exit_now;
  logic [N-1:0]     q_fin;

  // Partial remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    p_sh      = {p, dvd[N-1]};
    p_ge      = (p_sh >= {1'b0, dsr});
    diff      = p_sh[WIDTH-1:0] - dsr;
    p_nx      = p_ge ? diff : p_sh[WIDTH-1:0];
    q_nx      = {q_sr[N-2:0], p_ge};
    dvd_nx    = {dvd[N-2:0], 1'b0};
    last_step = (cnt == '0);
`ifdef DIVMOD_EARLY_EXIT_EN
    exit_now  = last_step || ((p_nx == '0) && (dvd_nx == '0));
    q_fin     = q_nx << cnt;
`else
    exit_now  = last_step;
    q_fin     = q_nx;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      dvd       <= '0;
      q_sr      <= '0;
      p         <= '0;
      dsr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            if (op2 == '0) begin
              quotient  <= '1;
              remainder <= '1;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              dvd      <= {op1, {FRAC{1'b0}}};
              q_sr     <= '0;
              p        <= '0;
              dsr      <= op2;
              cnt      <= CW'(N - 1);
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= ITER;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ITER: begin
          p    <= p_nx;
          dvd  <= dvd_nx;
          q_sr <= q_nx;
          cnt  <= cnt - 1'b1;
          if (exit_now) begin
            quotient  <= q_fin;
            remainder <= p_nx;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_seq_ctrl.sv
// Directed bench for divmod_seq_ctrl; latency figures are edge counts after the acceptance edge E0.
module tb_divmod_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] op1 = '0;
  logic [3:0] op2 = '0;
  logic       in_ready, out_valid, div_zero, busy;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int checks = 0;
  int failures = 0;

`ifdef DIVMOD_EARLY_EXIT_EN
  localparam int LAT_15_4 = 6;
  localparam int LAT_8_2  = 2;
`else
  localparam int LAT_15_4 = 8;
  localparam int LAT_8_2  = 8;
`endif
  localparam int LAT_7_3 = 8;

  divmod_seq_ctrl #(.WIDTH(4), .FRAC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge right after acceptance edge E0.
  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, div_zero, quotient, remainder} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b dz=%b q=%h r=%h required all 0",
               in_ready, out_valid, busy, div_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got rdy=%b busy=%b vld=%b required 1/0/0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_divide(input logic [3:0] a, input logic [3:0] b,
                             input logic [7:0] eq, input logic [3:0] er, input int elat);
    int lat;
    out_ready = 1'b1;
    accept(a, b);
    op1 = ~a;
    op2 = b + 4'd1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL iter_flags %0d/%0d got busy=%b rdy=%b required 1/0", a, b, busy, in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat != elat) begin
      failures++;
      $display("FAIL latency %0d/%0d got %0d required %0d", a, b, lat, elat);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_zero !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL result %0d/%0d got q=%h r=%h dz=%b busy=%b required q=%h r=%h dz=0 busy=0",
               a, b, quotient, remainder, div_zero, busy, eq, er);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== eq) begin
      failures++;
      $display("FAIL consumed %0d/%0d got vld=%b rdy=%b q=%h required 0/1/%h",
               a, b, out_valid, in_ready, quotient, eq);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    out_ready = 1'b1;
    accept(4'd9, 4'd0);
    lat = 0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL dz_latency got vld=%b busy=%b after E0 required vld=1 busy=0", out_valid, busy);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 4'hF || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_result got q=%h r=%h dz=%b required ff/f/1", quotient, remainder, div_zero);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_consumed got vld=%b rdy=%b dz=%b required 0/1/1", out_valid, in_ready, div_zero);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic bad;
    out_ready = 1'b0;
    accept(4'd8, 4'd2);
    wait_valid(lat);
    checks++;
    if (lat != LAT_8_2) begin
      failures++;
      $display("FAIL stall_latency got %0d required %0d", lat, LAT_8_2);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op1 = 4'd1;
      op2 = 4'd1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'h40 || remainder !== 4'h0)
        bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || out_valid !== 1'b1 || quotient !== 8'h40) begin
      failures++;
      $display("FAIL stall_hold got vld=%b rdy=%b q=%h r=%h required 1/0/40/0 throughout",
               out_valid, in_ready, quotient, remainder);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'h40) begin
      failures++;
      $display("FAIL stall_release got vld=%b rdy=%b q=%h required 0/1/40", out_valid, in_ready, quotient);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_no_ghost got busy=%b vld=%b rdy=%b required 0/0/1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic seen;
    out_ready = 1'b1;
    accept(4'd15, 4'd4);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, div_zero, quotient, remainder} !== 16'h0) begin
      failures++;
      $display("FAIL midrst_outputs got rdy=%b vld=%b busy=%b dz=%b q=%h r=%h required all 0",
               in_ready, out_valid, busy, div_zero, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midrst_no_result got out_valid=1 required 0");
    end
    test_divide(4'd5, 4'd5, 8'h10, 4'h0,
`ifdef DIVMOD_EARLY_EXIT_EN
                4
`else
                8
`endif
    );
  endtask

  task automatic test_back_to_back();
    int budget;
    bit got;
    logic [7:0] eq;
    logic [3:0] er;
    logic       edz;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'hFF; er = 4'hF; edz = 1'b1;
        end else begin
          eq = 8'((a * 16) / b); er = 4'((a * 16) % b); edz = 1'b0;
        end
        out_ready = 1'($urandom_range(0, 1));
        accept(4'(a), 4'(b));
        got = 1'b0;
        budget = 0;
        while (!got && budget < 60) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            got = 1'b1;
            checks++;
            if (quotient !== eq || remainder !== er || div_zero !== edz) begin
              failures++;
              $display("FAIL b2b %0d/%0d got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                       a, b, quotient, remainder, div_zero, eq, er, edz);
            end
          end
          @(negedge clk);
          budget++;
        end
        checks++;
        if (!got || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_handshake %0d/%0d got delivered=%0d vld_after=%b required 1/0",
                   a, b, got, out_valid);
        end
        out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_divide(4'd15, 4'd4, 8'h3C, 4'h0, LAT_15_4);
    test_divide(4'd7, 4'd3, 8'h25, 4'h1, LAT_7_3);
    test_divide(4'd15, 4'd1, 8'hF0, 4'h0,
`ifdef DIVMOD_EARLY_EXIT_EN
                4
`else
                8
`endif
    );
    test_div_zero();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divmod_seq_ctrl.md
Name: divmod_seq_ctrl

Overview:
- Sequencing controller for the calculator's divide path: accepts one operand pair per transaction and runs a restoring divider, one quotient bit per clock.
- Produces a fixed-point quotient (WIDTH integer bits + FRAC fractional bits) and a remainder.
- Sits between the operand/keypad logic (valid/ready in) and the LCD formatter (valid/ready out).
- Replaces the purely combinational divide with a timed, handshaked unit.

Parameters:
- WIDTH, 4, operand width (dividend, divisor, remainder, integer part of quotient)
- FRAC, 4, number of fractional quotient bits

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- op1  in  WIDTH  dividend, sampled only on acceptance
- op2  in  WIDTH  divisor, sampled only on acceptance
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH+FRAC  floor(op1*2^FRAC / op2)
- remainder  out  WIDTH  (op1*2^FRAC) mod op2
- div_zero  out  1  result is the divide-by-zero code
- busy  out  1  high in ITER

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - quotient=0, remainder=0, div_zero=0, out_valid=0, busy=0, in_ready=0 while in reset
  - Mid-operation reset aborts the transaction; no result is produced.
- FSM states: IDLE, ITER, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 only in ITER.
- Accept edge E0 (IDLE, in_valid=1):
  - If op2==0: go to DONE with quotient=all ones, remainder=all ones, div_zero=1; out_valid visible after E0 (latency 1).
  - Else: load dividend shift register = {op1, FRAC zeros}, partial remainder P=0 (WIDTH+1 bits, so no overflow), step count=0, div_zero=0; go to ITER.
- ITER, each edge:
  - P = {P, next dividend MSB}.
  - If P>=op2: P=P-op2, shift in quotient bit 1; else shift in 0.
  - count++.
  - After WIDTH+FRAC steps (edge E8 for defaults): go to DONE; quotient = shifted bits, remainder = P[WIDTH-1:0].
  - Normal latency: WIDTH+FRAC cycles from acceptance to out_valid.
- DONE:
  - Outputs held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE. in_ready rises the next cycle (no same-cycle bypass).
  - quotient/remainder/div_zero keep their last values in IDLE.
- in_valid while not in IDLE is ignored; op1/op2 changes outside acceptance have no effect.
- Max value (op1=15, op2=1): quotient=0xF0, fits in WIDTH+FRAC bits.

Optional Feature:
- Macro: DIVMOD_EARLY_EXIT_EN.
- Defined: in ITER, if after a step P==0 and all unconsumed dividend bits are zero, go to DONE on that same edge. Remaining quotient bits are filled with 0; remainder=0. Latency = steps actually performed (minimum 1).
- Undefined: always exactly WIDTH+FRAC steps.
- Results are identical either way; only latency differs.

Test Plan:
- op1=15, op2=4, out_ready=1 → quotient=0x3C (3.75), remainder=0, div_zero=0; out_valid 8 cycles after acceptance (6 with DIVMOD_EARLY_EXIT_EN).
- op1=7, op2=3 → quotient=0x25, remainder=1, latency 8 in both builds.
- op1=9, op2=0 → quotient=0xFF, remainder=0xF, div_zero=1, out_valid 1 cycle after acceptance.
- op1=8, op2=2, out_ready held 0 for 5 cycles after out_valid → quotient=0x40, remainder=0 stable throughout; in_ready stays 0; in_valid pulses ignored; IDLE one cycle after out_ready=1. Early-exit build: latency 2.
- rst_n low during 4th ITER cycle → all outputs 0, no out_valid; next transaction 5/5 returns quotient=0x10, remainder=0.
- All 256 op1/op2 pairs back-to-back with random out_ready → every result matches floor(op1*16/op2) and (op1*16) mod op2; handshake never drops or duplicates a result.
